// File: rtl/conv1d_sa_driver_pkg.sv
// Shared accelerator definitions: driver FSM encoding and weight-select constants.
package conv1d_sa_driver_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    LOAD_X,
    PRIME,
    STREAM,
    DONE
  } state_e;

  localparam logic [31:0] WR_INDEX_NONE = 32'd0;

endpackage

// File: rtl/conv1d_sa_driver_sample_buf.sv
// Sample buffer: one write port, one read port with a registered read.
module conv1d_sample_buf #(
  parameter int DataWidth = 32,
  parameter int Depth     = 10,
  localparam int AW       = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [DataWidth-1:0] wr_data,
  input  logic [AW-1:0]        rd_addr,
  output logic [DataWidth-1:0] rd_data
);

  logic [DataWidth-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd_data <= '0;
    else      rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/conv1d_sa_driver.sv
// Loads a kernel into the systolic array weight registers, buffers the signal,
// then streams it (plus KernelLen zeros of flush) into the array.
module conv1d_sa_driver
  import conv1d_sa_driver_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int KernelLen = 10,
  parameter int SigLen    = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 s_valid,
  input  logic [DataWidth-1:0] s_data,
  output logic                 s_ready,
  output logic                 sa_rst,
  output logic                 sa_trigger,
  output logic [DataWidth-1:0] sa_data,
  output logic [31:0]          sa_wr_index,
  output logic [DataWidth-1:0] sa_wr_value,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = $clog2(SigLen + KernelLen + 1);
  localparam int AW = (SigLen > 1) ? $clog2(SigLen) : 1;
  localparam logic [CW-1:0] W_LAST = CW'(KernelLen - 1);
  localparam logic [CW-1:0] X_LAST = CW'(SigLen - 1);
  localparam logic [CW-1:0] X_END  = CW'(SigLen);
  localparam logic [CW-1:0] S_LAST = CW'(SigLen + KernelLen - 1);

  state_e               state, next;
  logic [CW-1:0]        cnt;
  logic                 beat;
  logic [AW-1:0]        rd_addr;
  logic [DataWidth-1:0] rd_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next;
  end

  always_comb begin
    next    = state;
    s_ready = 1'b0;
    case (state)
      IDLE:   if (start) next = LOAD_W;
      LOAD_W: begin
        s_ready = 1'b1;
        if (s_valid && cnt == W_LAST) next = LOAD_X;
      end
      LOAD_X: begin
        s_ready = 1'b1;
        if (s_valid && cnt == X_LAST) next = PRIME;
      end
      PRIME:  next = STREAM;
      STREAM: if (cnt == S_LAST) next = DONE;
      DONE:   next = IDLE;
      default: next = IDLE;
    endcase
  end

  assign beat = s_valid & s_ready;
  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // Read runs one entry ahead so the registered read lines up with STREAM cycle c.
  always_comb begin
    rd_addr = '0;
    if (state == STREAM && cnt < X_LAST) rd_addr = AW'(cnt + CW'(1));
  end

  conv1d_sample_buf #(
    .DataWidth (DataWidth),
    .Depth     (SigLen)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (beat && state == LOAD_X),
    .wr_addr (AW'(cnt)),
    .wr_data (s_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt         <= '0;
      sa_rst      <= 1'b0;
      sa_trigger  <= 1'b0;
      sa_data     <= '0;
      sa_wr_index <= WR_INDEX_NONE;
      sa_wr_value <= '0;
    end else begin
      if (next != state)                  cnt <= '0;
      else if (beat || state == STREAM)   cnt <= cnt + CW'(1);
      sa_rst     <= (state == PRIME);
      sa_trigger <= (state == STREAM);
      sa_data    <= (state == STREAM && cnt < X_END) ? rd_data : '0;
      if (beat && state == LOAD_W) begin
        sa_wr_index <= 32'(cnt) + 32'd1;
        sa_wr_value <= s_data;
      end else begin
        sa_wr_index <= WR_INDEX_NONE;
      end
    end
  end

endmodule

// File: tb/tb_conv1d_sa_driver.sv
// Bench for conv1d_sa_driver: event logs plus a behavioural array model checked against direct convolution.
module tb_conv1d_sa_driver;
  localparam int DW = 32, K = 10, S = 10, N = K + S;

  logic clk = 1'b0, rst = 1'b0, start = 1'b0, s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic s_ready, sa_rst, sa_trigger, busy, done;
  logic [DW-1:0] sa_data, sa_wr_value;
  logic [31:0] sa_wr_index;

  always #5 clk = ~clk;

  conv1d_sa_driver #(.DataWidth(DW), .KernelLen(K), .SigLen(S)) dut (
    .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .sa_rst(sa_rst), .sa_trigger(sa_trigger), .sa_data(sa_data),
    .sa_wr_index(sa_wr_index), .sa_wr_value(sa_wr_value), .busy(busy), .done(done)
  );

  int n_checks = 0, n_fail = 0, cyc = 0;
  logic [DW-1:0] kern [K];
  logic [DW-1:0] samp [S];
  int beat_q[$], wr_cyc_q[$], rst_q[$], trig_cyc_q[$], done_q[$];
  logic [31:0] wr_idx_q[$];
  logic [DW-1:0] wr_val_q[$], trig_dat_q[$], y_q[$];
  logic [DW-1:0] pe_w [K];
  logic [DW-1:0] chain [K];

  always @(posedge clk) cyc <= cyc + 1;

  // Array model: weights per PE, a shift chain of streamed samples, dot product per trigger.
  function automatic logic [DW-1:0] calc_y(input logic [DW-1:0] din);
    logic [DW-1:0] acc = '0;
    for (int k = 0; k < K; k++) acc += pe_w[k] * ((k == 0) ? din : chain[k-1]);
    return acc;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      if (s_valid && s_ready) beat_q.push_back(cyc);
      if (sa_wr_index != 0) begin
        wr_cyc_q.push_back(cyc); wr_idx_q.push_back(sa_wr_index); wr_val_q.push_back(sa_wr_value);
        if (sa_wr_index <= K) pe_w[sa_wr_index-1] <= sa_wr_value;
      end
      if (sa_rst) begin
        rst_q.push_back(cyc);
        for (int k = 0; k < K; k++) chain[k] <= '0;
      end
      if (sa_trigger) begin
        trig_cyc_q.push_back(cyc); trig_dat_q.push_back(sa_data);
        y_q.push_back(calc_y(sa_data));
        chain[0] <= sa_data;
        for (int k = 1; k < K; k++) chain[k] <= chain[k-1];
      end
      if (done) done_q.push_back(cyc);
    end
  end

  task automatic clear_logs();
    beat_q.delete(); wr_cyc_q.delete(); rst_q.delete(); trig_cyc_q.delete(); done_q.delete();
    wr_idx_q.delete(); wr_val_q.delete(); trig_dat_q.delete(); y_q.delete();
  endtask

  task automatic start_job();
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
  endtask

  // mode 0: gapless, 1: one idle cycle before every word, 2: random idle cycles
  task automatic send_word(input logic [DW-1:0] w, input int mode);
    int tries = 0;
    logic ok;
    if (mode == 1 || (mode == 2 && $urandom_range(0, 2) == 0)) begin
      s_valid = 1'b0; @(posedge clk); #1;
    end
    s_valid = 1'b1; s_data = w;
    forever begin
      ok = s_ready;
      @(posedge clk); #1;
      if (ok) break;
      tries++;
      if (tries > 50) begin
        n_checks++; n_fail++;
        $display("FAIL send_word: s_ready stuck low for %0d cycles, required 1", tries);
        break;
      end
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      if (done_q.size() > 0) return;
    end
    n_checks++; n_fail++;
    $display("FAIL wait_done: done count 0 after 300 cycles, required 1");
  endtask

  task automatic wait_trig(input int n);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      if (trig_cyc_q.size() >= n) return;
    end
    n_checks++; n_fail++;
    $display("FAIL wait_trig: %0d triggers seen, required %0d", trig_cyc_q.size(), n);
  endtask

  task automatic send_all(input int mode);
    for (int j = 0; j < K; j++) send_word(kern[j], mode);
    for (int j = 0; j < S; j++) send_word(samp[j], mode);
    s_valid = 1'b0;
  endtask

  task automatic run_job(input int mode);
    clear_logs(); start_job(); send_all(mode); wait_done();
    @(posedge clk); #1;
  endtask

  task automatic check_outputs_idle(input string name);
    n_checks++;
    if ({s_ready, busy, done, sa_rst, sa_trigger} !== 5'b0 || sa_data !== '0 ||
        sa_wr_index !== 32'd0 || sa_wr_value !== '0) begin
      n_fail++;
      $display("FAIL %s: rdy/busy/done/rst/trig=%b data=%0h idx=%0d val=%0h, required all 0",
               name, {s_ready, busy, done, sa_rst, sa_trigger}, sa_data, sa_wr_index, sa_wr_value);
    end
  endtask

  task automatic check_job(input string name);
    logic [DW-1:0] exp_d, r;
    n_checks++;
    if (beat_q.size() !== N) begin n_fail++; $display("FAIL %s beats: %0d, required %0d", name, beat_q.size(), N); end
    n_checks++;
    if (wr_idx_q.size() !== K) begin n_fail++; $display("FAIL %s wr_count: %0d, required %0d", name, wr_idx_q.size(), K); end
    for (int j = 0; j < K && j < wr_idx_q.size() && j < beat_q.size(); j++) begin
      n_checks++;
      if (wr_idx_q[j] !== 32'(j + 1) || wr_val_q[j] !== kern[j] || wr_cyc_q[j] !== beat_q[j] + 1) begin
        n_fail++;
        $display("FAIL %s wr[%0d]: idx=%0d val=%0h cyc=%0d, required idx=%0d val=%0h cyc=%0d",
                 name, j, wr_idx_q[j], wr_val_q[j], wr_cyc_q[j], j + 1, kern[j], beat_q[j] + 1);
      end
    end
    n_checks++;
    if (rst_q.size() !== 1 || (beat_q.size() == N && rst_q[0] !== beat_q[N-1] + 2)) begin
      n_fail++;
      $display("FAIL %s sa_rst: pulses=%0d first=%0d, required 1 pulse 2 cycles after last beat",
               name, rst_q.size(), (rst_q.size() > 0) ? rst_q[0] : -1);
    end
    n_checks++;
    if (trig_cyc_q.size() !== N) begin n_fail++; $display("FAIL %s triggers: %0d, required %0d", name, trig_cyc_q.size(), N); end
    for (int c = 0; c < N && c < trig_cyc_q.size() && rst_q.size() > 0; c++) begin
      exp_d = (c < S) ? samp[c] : '0;
      n_checks++;
      if (trig_cyc_q[c] !== rst_q[0] + 1 + c || trig_dat_q[c] !== exp_d) begin
        n_fail++;
        $display("FAIL %s stream[%0d]: cyc=%0d data=%0h, required cyc=%0d data=%0h",
                 name, c, trig_cyc_q[c], trig_dat_q[c], rst_q[0] + 1 + c, exp_d);
      end
    end
    n_checks++;
    if (done_q.size() !== 1 || (trig_cyc_q.size() > 0 && done_q[0] !== trig_cyc_q[trig_cyc_q.size()-1])) begin
      n_fail++;
      $display("FAIL %s done: pulses=%0d, required 1 in the DONE cycle", name, done_q.size());
    end
    for (int n = 0; n < N - 1 && n < y_q.size(); n++) begin
      r = '0;
      for (int k = 0; k < K; k++) if (n - k >= 0 && n - k < S) r += kern[k] * samp[n-k];
      n_checks++;
      if (y_q[n] !== r) begin
        n_fail++;
        $display("FAIL %s conv[%0d]: %0h, required %0h", name, n, y_q[n], r);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; s_valid = 1'b0;
    repeat (3) @(posedge clk); #1;
    check_outputs_idle("reset");
    rst = 1'b1; @(posedge clk); #1;
    check_outputs_idle("idle_after_reset");
  endtask

  task automatic test_basic();
    for (int j = 0; j < K; j++) kern[j] = DW'(j + 1);
    for (int j = 0; j < S; j++) samp[j] = DW'(j + 1);
    run_job(0); check_job("basic");
  endtask

  task automatic test_gaps();
    run_job(1); check_job("gaps");
  endtask

  task automatic test_conv_ones();
    for (int j = 0; j < K; j++) kern[j] = DW'(1);
    for (int j = 0; j < S; j++) samp[j] = DW'(2);
    run_job(2); check_job("conv_ones");
  endtask

  task automatic test_random();
    for (int t = 0; t < 2; t++) begin
      for (int j = 0; j < K; j++) kern[j] = $urandom;
      for (int j = 0; j < S; j++) samp[j] = $urandom;
      run_job(2); check_job("random");
    end
  endtask

  task automatic test_mid_reset();
    clear_logs(); start_job(); send_all(0); wait_trig(5);
    rst = 1'b0; #1;
    check_outputs_idle("mid_reset");
    @(posedge clk); #1; rst = 1'b1;
    for (int j = 0; j < K; j++) kern[j] = $urandom_range(0, 255);
    for (int j = 0; j < S; j++) samp[j] = $urandom_range(0, 255);
    run_job(0); check_job("after_reset");
  endtask

  task automatic test_start_ignored();
    clear_logs(); start_job();
    for (int j = 0; j < K; j++) send_word(kern[j], 0);
    start = 1'b1;
    for (int j = 0; j < S; j++) begin send_word(samp[j], 0); start = 1'b0; end
    s_valid = 1'b0;
    wait_trig(3);
    @(posedge clk); #1; start = 1'b1; @(posedge clk); #1; start = 1'b0;
    wait_done();
    repeat (30) @(posedge clk); #1;
    n_checks++;
    if (done_q.size() !== 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL start_ignored: done pulses=%0d busy=%b, required 1 and 0", done_q.size(), busy);
    end
    check_job("start_ignored");
  endtask

  task automatic test_back_to_back();
    for (int j = 0; j < K; j++) kern[j] = $urandom_range(1, 1000);
    for (int j = 0; j < S; j++) samp[j] = $urandom_range(1, 1000);
    run_job(0); check_job("b2b_first");
    for (int j = 0; j < K; j++) kern[j] = $urandom_range(1001, 2000);
    for (int j = 0; j < S; j++) samp[j] = $urandom_range(1, 1000);
    run_job(2); check_job("b2b_second");
  endtask

  initial begin
    for (int k = 0; k < K; k++) begin pe_w[k] = '0; chain[k] = '0; end
    test_reset();
    test_basic();
    test_gaps();
    test_conv_ones();
    test_random();
    test_mid_reset();
    test_start_ignored();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
